// File: rtl/hex_display_ctrl.sv
// Seven-segment display controller: handshaked loads are decoded one digit per cycle
// through a single hex decoder, then committed to the display in one step.
module hex_display_ctrl #(
    parameter int DIGITS     = 4,
    parameter int BLINK_DIV  = 25_000_000,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Rst,
    input  logic                  load_valid,
    output logic                  load_ready,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  lz_blank,
    input  logic                  blink_en,
    output logic [7*DIGITS-1:0]   seg_out,
    output logic [4*DIGITS-1:0]   disp_value
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SCAN   = 2'd1,
        S_COMMIT = 2'd2
    } state_t;

    // Active-high lit pattern, bit order g f e d c b a.
    function automatic logic [6:0] hex_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_seg = 7'h3F;
            4'h1: hex_seg = 7'h06;
            4'h2: hex_seg = 7'h5B;
            4'h3: hex_seg = 7'h4F;
            4'h4: hex_seg = 7'h66;
            4'h5: hex_seg = 7'h6D;
            4'h6: hex_seg = 7'h7D;
            4'h7: hex_seg = 7'h07;
            4'h8: hex_seg = 7'h7F;
            4'h9: hex_seg = 7'h67;
            4'hA: hex_seg = 7'h77;
            4'hB: hex_seg = 7'h7C;
            4'hC: hex_seg = 7'h58;
            4'hD: hex_seg = 7'h5E;
            4'hE: hex_seg = 7'h79;
            default: hex_seg = 7'h71;
        endcase
    endfunction

    state_t                 r_state;
    state_t                 w_next;
    logic [4*DIGITS-1:0]    r_value;
    logic                   r_lz;
    logic [IDX_W-1:0]       r_idx;
    logic                   r_lead;
    logic [7*DIGITS-1:0]    r_stage;
    logic [7*DIGITS-1:0]    r_commit;
    logic [4*DIGITS-1:0]    r_disp;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_phase;

    logic [3:0]             w_nib;
    logic                   w_blank_digit;
    logic [6:0]             w_stage_seg;
    logic [7*DIGITS-1:0]    w_pattern;

    assign w_nib         = r_value[4*r_idx +: 4];
    // Digit 0 is always shown so a zero value still displays "0".
    assign w_blank_digit = r_lz && r_lead && (w_nib == 4'h0) && (r_idx != '0);
    assign w_stage_seg   = w_blank_digit ? 7'h00 : hex_seg(w_nib);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (load_valid) w_next = S_SCAN;
            S_SCAN:   if (r_idx == '0) w_next = S_COMMIT;
            S_COMMIT: w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state  <= S_IDLE;
            r_value  <= '0;
            r_lz     <= 1'b0;
            r_idx    <= '0;
            r_lead   <= 1'b0;
            r_stage  <= '0;
            r_commit <= '0;
            r_disp   <= '0;
            r_cnt    <= '0;
            r_phase  <= 1'b0;
        end else begin
            r_state <= w_next;

            if (r_cnt == CNT_TOP) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                S_IDLE: begin
                    if (load_valid) begin
                        r_value <= value;
                        r_lz    <= lz_blank;
                        r_idx   <= IDX_TOP;
                        r_lead  <= 1'b1;
                    end
                end
                S_SCAN: begin
                    r_stage[7*r_idx +: 7] <= w_stage_seg;
                    if (!w_blank_digit) r_lead <= 1'b0;
                    if (r_idx != '0) r_idx <= r_idx - 1'b1;
                end
                S_COMMIT: begin
                    r_commit <= r_stage;
                    r_disp   <= r_value;
                end
                default: ;
            endcase
        end
    end

    assign w_pattern  = ACTIVE_LOW ? ~r_commit : r_commit;
    assign seg_out    = (blink_en && r_phase) ? {(7*DIGITS){ACTIVE_LOW}} : w_pattern;
    assign load_ready = (r_state == S_IDLE);
    assign disp_value = r_disp;

endmodule
